// File: rtl/ddr2_fifo_responder_pkg.sv
// ddr2_fifo_responder_pkg: shared command codes, burst size and FSM state type.
// Ports: none (package only).
package ddr2_resp_pkg;
    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ = 3'b001;
    localparam int BEATS_PER_BURST = 2;
    typedef enum logic [2:0] {IDLE, WR0, WR1, RD_WAIT, RD0, RD1} state_t;
endpackage

// File: rtl/ddr2_fifo_responder_sync_fifo.sv
// sync_fifo: first-word-fall-through synchronous FIFO with occupancy count.
// Ports: clk, rst (sync, active-high); din_i/wr_en_i push side;
//        dout_o/rd_en_i pop side (dout_o reads 0 when empty);
//        count_o occupancy, full_o, empty_o derived from the registered count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     wr_en_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0] cnt_q;
    logic push, pop;
    // A push while full is dropped even if a pop happens in the same cycle.
    assign push = wr_en_i && !full_o;
    assign pop = rd_en_i && !empty_o;
    assign full_o = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign count_o = cnt_q;
    assign dout_o = empty_o ? '0 : mem_q[rp_q];
    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q <= '0;
            rp_q <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wp_q <= wp_q + AW'(1);
            if (pop) rp_q <= rp_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q] <= din_i;
    end
endmodule

// File: rtl/ddr2_fifo_responder.sv
// ddr2_fifo_responder: DDR2-controller stand-in servicing 2-beat bursts from a 128-bit row memory.
// Ports: clk, rst (sync, active-high);
//        af_cmd_din/af_addr_din/af_wr_en/af_full  command FIFO push side;
//        wdf_din/wdf_mask_din/wdf_wr_en/wdf_full  write-data FIFO push side (mask 1 = keep byte);
//        rdf_dout/rdf_valid/rdf_rd_en             read-data FIFO, first-word-fall-through;
//        err                                      sticky protocol error.
module ddr2_fifo_responder import ddr2_resp_pkg::*; #(
    parameter int ADDR_W = 10,
    parameter int AF_DEPTH = 8,
    parameter int WDF_DEPTH = 16,
    parameter int RDF_DEPTH = 16,
    parameter int RD_LATENCY = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [2:0]   af_cmd_din,
    input  logic [30:0]  af_addr_din,
    input  logic         af_wr_en,
    output logic         af_full,
    input  logic [127:0] wdf_din,
    input  logic [15:0]  wdf_mask_din,
    input  logic         wdf_wr_en,
    output logic         wdf_full,
    output logic [127:0] rdf_dout,
    output logic         rdf_valid,
    input  logic         rdf_rd_en,
    output logic         err
);
    localparam int CW = $clog2(RD_LATENCY + 1);
    localparam int RAW = $clog2(RDF_DEPTH);
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [ADDR_W-2:0] base_q, base_d;
    logic err_q, err_d;
    logic [33:0] af_dout;
    logic [143:0] wdf_dout;
    logic [$clog2(AF_DEPTH):0] af_cnt;
    logic [$clog2(WDF_DEPTH):0] wdf_cnt;
    logic [RAW:0] rdf_cnt;
    logic af_empty, wdf_empty, rdf_empty;
    logic af_pop, wdf_pop, rdf_push, beat, bad_cmd, cnt_done, rdf_room;
    logic [2:0] cmd;
    logic [ADDR_W-1:0] row;
    logic [127:0] mem_q [2**ADDR_W];
    logic unused_bits;
    sync_fifo #(.WIDTH(34), .DEPTH(AF_DEPTH)) u_af (
        .clk(clk), .rst(rst), .din_i({af_cmd_din, af_addr_din}), .wr_en_i(af_wr_en),
        .rd_en_i(af_pop), .dout_o(af_dout), .count_o(af_cnt), .full_o(af_full), .empty_o(af_empty)
    );
    sync_fifo #(.WIDTH(144), .DEPTH(WDF_DEPTH)) u_wdf (
        .clk(clk), .rst(rst), .din_i({wdf_mask_din, wdf_din}), .wr_en_i(wdf_wr_en),
        .rd_en_i(wdf_pop), .dout_o(wdf_dout), .count_o(wdf_cnt), .full_o(wdf_full), .empty_o(wdf_empty)
    );
    sync_fifo #(.WIDTH(128), .DEPTH(RDF_DEPTH)) u_rdf (
        .clk(clk), .rst(rst), .din_i(mem_q[row]), .wr_en_i(rdf_push),
        .rd_en_i(rdf_rd_en), .dout_o(rdf_dout), .count_o(rdf_cnt), .full_o(), .empty_o(rdf_empty)
    );
    // Address bits outside the row index alias onto the same rows by design.
    assign unused_bits = ^{af_cnt, wdf_cnt, af_dout[30:ADDR_W+1], af_dout[1:0]};
    assign cmd = af_dout[33:31];
    assign cnt_done = cnt_q == CW'(RD_LATENCY - 1);
    // A read burst only starts once both beats are guaranteed to fit.
    assign rdf_room = rdf_cnt <= (RAW+1)'(RDF_DEPTH - BEATS_PER_BURST);
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            base_q <= '0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            base_q <= base_d;
            err_q <= err_d;
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d = '0;
        base_d = base_q;
        case (state_q)
            IDLE: if (!af_empty) begin
                base_d = af_dout[ADDR_W:2];
                state_d = cmd == CMD_WRITE ? WR0 : cmd == CMD_READ ? RD_WAIT : IDLE;
            end
            WR0: state_d = wdf_empty ? WR0 : WR1;
            WR1: state_d = wdf_empty ? WR1 : IDLE;
            RD_WAIT: begin
                cnt_d = cnt_done ? cnt_q : cnt_q + CW'(1);
                state_d = cnt_done && rdf_room ? RD0 : RD_WAIT;
            end
            RD0: state_d = RD1;
            RD1: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        af_pop = state_q == IDLE && !af_empty;
        bad_cmd = af_pop && cmd != CMD_WRITE && cmd != CMD_READ;
        wdf_pop = (state_q == WR0 || state_q == WR1) && !wdf_empty;
        rdf_push = state_q == RD0 || state_q == RD1;
        beat = state_q == WR1 || state_q == RD1;
        row = {base_q, beat};
        err_d = err_q | bad_cmd | (af_wr_en && af_full) | (wdf_wr_en && wdf_full) | (rdf_rd_en && rdf_empty);
    end
    always_ff @(posedge clk) begin
        if (wdf_pop && !rst)
            for (int b = 0; b < 16; b++)
                if (!wdf_dout[128+b]) mem_q[row][8*b +: 8] <= wdf_dout[8*b +: 8];
    end
    assign rdf_valid = !rdf_empty;
    assign err = err_q;
endmodule

// File: tb/tb_ddr2_fifo_responder.sv
// tb_ddr2_fifo_responder: table-driven and scoreboard bench for ddr2_fifo_responder.
module tb_ddr2_fifo_responder;
    localparam int L = 4;
    logic clk = 1'b0;
    logic rst;
    logic [2:0] af_cmd_din;
    logic [30:0] af_addr_din;
    logic af_wr_en, af_full;
    logic [127:0] wdf_din;
    logic [15:0] wdf_mask_din;
    logic wdf_wr_en, wdf_full;
    logic [127:0] rdf_dout;
    logic rdf_valid, rdf_rd_en, err;
    int checks = 0;
    int errors = 0;
    logic [127:0] model [1024];
    logic [127:0] expq [$];
    typedef struct {
        logic is_wr;
        logic [30:0] addr;
        logic [127:0] d0;
        logic [127:0] d1;
        logic [15:0] m;
    } vec_t;
    vec_t tbl [9];

    ddr2_fifo_responder #(.ADDR_W(10), .AF_DEPTH(8), .WDF_DEPTH(16), .RDF_DEPTH(16), .RD_LATENCY(L)) dut (
        .clk(clk), .rst(rst), .af_cmd_din(af_cmd_din), .af_addr_din(af_addr_din), .af_wr_en(af_wr_en),
        .af_full(af_full), .wdf_din(wdf_din), .wdf_mask_din(wdf_mask_din), .wdf_wr_en(wdf_wr_en),
        .wdf_full(wdf_full), .rdf_dout(rdf_dout), .rdf_valid(rdf_valid), .rdf_rd_en(rdf_rd_en), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out", name);
    endtask

    function automatic int ridx(input logic [30:0] a, input logic b);
        return int'({a[10:2], b});
    endfunction

    task automatic model_wr(input logic [30:0] a, input logic b, input logic [127:0] d, input logic [15:0] m);
        int r = ridx(a, b);
        for (int i = 0; i < 16; i++)
            if (!m[i]) model[r][8*i +: 8] = d[8*i +: 8];
    endtask

    task automatic push_cmd(input logic [2:0] c, input logic [30:0] a);
        int n = 0;
        while (af_full && n < 500) begin
            tick();
            n++;
        end
        if (n >= 500) timeout("af_wait");
        af_cmd_din = c;
        af_addr_din = a;
        af_wr_en = 1'b1;
        tick();
        af_wr_en = 1'b0;
    endtask

    task automatic push_beat(input logic [127:0] d, input logic [15:0] m);
        int n = 0;
        while (wdf_full && n < 500) begin
            tick();
            n++;
        end
        if (n >= 500) timeout("wdf_wait");
        wdf_din = d;
        wdf_mask_din = m;
        wdf_wr_en = 1'b1;
        tick();
        wdf_wr_en = 1'b0;
    endtask

    task automatic wr(input logic [30:0] a, input logic [127:0] d0, input logic [127:0] d1, input logic [15:0] m);
        push_cmd(3'b000, a);
        push_beat(d0, m);
        push_beat(d1, m);
        model_wr(a, 1'b0, d0, m);
        model_wr(a, 1'b1, d1, m);
    endtask

    task automatic rd(input logic [30:0] a);
        push_cmd(3'b001, a);
        expq.push_back(model[ridx(a, 1'b0)]);
        expq.push_back(model[ridx(a, 1'b1)]);
    endtask

    task automatic drain(input int nbeats, input string name);
        int got = 0;
        int n = 0;
        while (got < nbeats && n < 3000) begin
            if (rdf_valid) begin
                if (expq.size() == 0) timeout({name, "_unexpected_beat"});
                else check(name, rdf_dout, expq.pop_front());
                rdf_rd_en = 1'b1;
                tick();
                rdf_rd_en = 1'b0;
                got++;
            end else begin
                tick();
                n++;
            end
        end
        if (got < nbeats) timeout(name);
    endtask

    initial begin
        int n;
        logic [127:0] masked;
        masked = {{15{8'hFF}}, 8'h00};
        tbl = '{
            '{1'b1, 31'h40,  128'h11, 128'h22, 16'h0000},
            '{1'b0, 31'h40,  128'h0,  128'h0,  16'h0000},
            '{1'b1, 31'h80,  {128{1'b1}}, {128{1'b1}}, 16'h0000},
            '{1'b1, 31'h80,  128'h0,  128'h0,  16'hFFFE},
            '{1'b0, 31'h80,  128'h0,  128'h0,  16'h0000},
            '{1'b0, 31'h840, 128'h0,  128'h0,  16'h0000},
            '{1'b1, 31'h47,  128'h0123456789ABCDEF_FEDCBA9876543210, 128'hDEADBEEF_CAFEF00D_A5A5A5A5_5A5A5A5A, 16'h0000},
            '{1'b1, 31'h44,  128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD, 128'h11112222_33334444_55556666_77778888, 16'h0F0F},
            '{1'b0, 31'h45,  128'h0,  128'h0,  16'h0000}
        };
        rst = 1'b1;
        af_cmd_din = '0;
        af_addr_din = '0;
        af_wr_en = 1'b0;
        wdf_din = '0;
        wdf_mask_din = '0;
        wdf_wr_en = 1'b0;
        rdf_rd_en = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_af_full", af_full, 0);
        check("rst_wdf_full", wdf_full, 0);
        check("rst_rdf_valid", rdf_valid, 0);
        check("rst_rdf_dout", rdf_dout, 0);
        check("rst_err", err, 0);

        for (int i = 0; i < 9; i++) begin
            if (tbl[i].is_wr) wr(tbl[i].addr, tbl[i].d0, tbl[i].d1, tbl[i].m);
            else rd(tbl[i].addr);
        end
        drain(expq.size(), "table_read");
        check("table_err", err, 0);

        push_cmd(3'b001, 31'h80);
        n = 0;
        while (!rdf_valid && n < 100) begin
            tick();
            n++;
        end
        check("masked_beat0", rdf_dout, masked);
        rdf_rd_en = 1'b1;
        tick();
        rdf_rd_en = 1'b0;
        check("masked_beat1", rdf_dout, masked);
        rdf_rd_en = 1'b1;
        tick();
        rdf_rd_en = 1'b0;

        rd(31'h40);
        n = 1;
        while (!rdf_valid && n < 100) begin
            tick();
            n++;
        end
        check("read_latency", n, L + 3);
        drain(2, "latency_read");

        for (int i = 0; i < 9; i++) rd(31'h40);
        repeat (100) tick();
        check("stall_valid", rdf_valid, 1);
        check("stall_err", err, 0);
        drain(2, "stall_pop2");
        repeat (30) tick();
        drain(16, "stall_rest");
        check("stall_queue_empty", expq.size(), 0);
        check("stall_err_after", err, 0);

        push_cmd(3'b000, 31'h100);
        push_beat(128'hBEEF0001, 16'h0000);
        model_wr(31'h100, 1'b0, 128'hBEEF0001, 16'h0000);
        push_cmd(3'b001, 31'h100);
        repeat (30) tick();
        check("wr1_hold", rdf_valid, 0);
        push_beat(128'hBEEF0002, 16'h0000);
        model_wr(31'h100, 1'b1, 128'hBEEF0002, 16'h0000);
        expq.push_back(model[ridx(31'h100, 1'b0)]);
        expq.push_back(model[ridx(31'h100, 1'b1)]);
        drain(2, "wr1_complete");

        push_cmd(3'b000, 31'h200);
        repeat (3) tick();
        for (int i = 0; i < 8; i++) push_cmd(3'b001, 31'h200);
        check("af_full_after_8", af_full, 1);
        check("af_err_before", err, 0);
        af_cmd_din = 3'b001;
        af_addr_din = 31'h200;
        af_wr_en = 1'b1;
        tick();
        af_wr_en = 1'b0;
        tick();
        check("af_overflow_err", err, 1);
        push_beat(128'h5555_0000, 16'h0000);
        push_beat(128'h5555_0001, 16'h0000);
        model_wr(31'h200, 1'b0, 128'h5555_0000, 16'h0000);
        model_wr(31'h200, 1'b1, 128'h5555_0001, 16'h0000);
        for (int i = 0; i < 8; i++) begin
            expq.push_back(model[ridx(31'h200, 1'b0)]);
            expq.push_back(model[ridx(31'h200, 1'b1)]);
        end
        drain(16, "af_queued_reads");
        repeat (50) tick();
        check("af_only_8_held", rdf_valid, 0);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("rst_clears_err", err, 0);

        push_cmd(3'b010, 31'h40);
        repeat (5) tick();
        check("bad_cmd_err", err, 1);
        rd(31'h40);
        drain(2, "bad_cmd_no_write");

        rst = 1'b1;
        tick();
        rst = 1'b0;
        rdf_rd_en = 1'b1;
        tick();
        rdf_rd_en = 1'b0;
        tick();
        check("pop_empty_err", err, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        rd(31'h80);
        n = 0;
        while (!rdf_valid && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) timeout("rd1_wait");
        rst = 1'b1;
        tick();
        check("rst_in_rd1_valid", rdf_valid, 0);
        check("rst_in_rd1_err", err, 0);
        rst = 1'b0;
        expq.delete();
        repeat (10) tick();
        check("rst_burst_abandoned", rdf_valid, 0);
        rd(31'h80);
        drain(2, "post_rst_memory");
        rd(31'h40);
        drain(2, "post_rst_memory2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
